// File: rtl/fir_param_core_if.sv
// fir_param_core_if: AXI-lite config bus plus AXI-stream in/out for fir_param_core
// Signals:
//   aw*/w*  AXI-lite write address/data channels (no response channel)
//   ar*/r*  AXI-lite read address/data channels
//   ss_*    input sample stream (host -> core)
//   sm_*    filtered output stream (core -> host)
// Modports: slave = core side, master = host/testbench side.
`timescale 1ns/1ps
interface fir_param_core_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   ss_tvalid;
  logic                   ss_tready;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   ss_tlast;
  logic                   sm_tvalid;
  logic                   sm_tready;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tlast;
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    output awready, wready, arready, rvalid, rdata,
    output ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );
  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    input  awready, wready, arready, rvalid, rdata,
    input  ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );
endinterface

// File: rtl/fir_param_core.sv
// fir_param_core: sequential FIR engine, register-held taps/history, one shared MAC
// Ports:
//   axis_clk    single clock
//   axis_rst_n  asynchronous active-low reset
//   bus         fir_param_core_if.slave: AXI-lite config + ss (samples in) + sm (results out)
// Register map: 0x00 ap_ctrl {tlast_err, ap_idle, ap_done, ap_start}, 0x10 data_length,
//   0x40+4k tap k (k < Tape_Num); anything else reads 0 and drops writes.
// Build option FIR_SAT_EN: clamp the output to the signed pDATA_WIDTH range
//   instead of taking the low bits of the accumulator.
`timescale 1ns/1ps
module fir_param_core #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input logic           axis_clk,
  input logic           axis_rst_n,
  fir_param_core_if.slave bus
);
  localparam int W  = pDATA_WIDTH;
  localparam int A  = pADDR_WIDTH;
  localparam int KW = Tape_Num > 1 ? $clog2(Tape_Num) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(Tape_Num - 1);
`ifdef FIR_SAT_EN
  localparam logic signed [2*W-1:0] S_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] S_MIN = ~S_MAX;
`endif
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_WAIT_IN, S_MAC, S_OUT, S_DONE} state_t;
  state_t                state;
  logic                  ap_start, ap_done, ap_idle, tlast_err;
  logic [W-1:0]          data_length, n;
  logic signed [W-1:0]   taps [Tape_Num];
  logic signed [W-1:0]   hist [Tape_Num];
  logic [KW-1:0]         head, rp, k;
  logic signed [2*W-1:0] acc, prod, sum;
  logic [W-1:0]          result, rd_val, ctrl_word;
  logic                  aw_hold, w_hold, rd_ctrl;
  logic [A-1:0]          aw_addr;
  logic [W-1:0]          w_data;
  logic [A-3:0]          rd_idx, wr_idx;
  logic                  wr_go, rd_done, rd_tap, wr_tap, last_n;
  // MAC datapath: k walks the taps while rp walks the history backwards from the newest sample.
  always_comb begin
    prod = (2*W)'(taps[k]) * (2*W)'(hist[rp]);
    sum = acc + prod;
`ifdef FIR_SAT_EN
    result = sum > S_MAX ? S_MAX[W-1:0] : sum < S_MIN ? S_MIN[W-1:0] : sum[W-1:0];
`else
    result = sum[W-1:0];
`endif
    last_n = n == data_length - W'(1);
    ctrl_word = {{(W-4){1'b0}}, tlast_err, ap_idle, ap_done, ap_start};
    rd_idx = bus.araddr[A-1:2] - (A-2)'('h10);
    wr_idx = aw_addr[A-1:2] - (A-2)'('h10);
    rd_tap = bus.araddr[A-1:2] >= (A-2)'('h10) && bus.araddr[1:0] == 2'b00 && rd_idx < (A-2)'(Tape_Num);
    wr_tap = aw_addr[A-1:2] >= (A-2)'('h10) && aw_addr[1:0] == 2'b00 && wr_idx < (A-2)'(Tape_Num);
    rd_val = bus.araddr == '0 ? ctrl_word :
             bus.araddr == A'('h10) ? data_length :
             rd_tap ? taps[rd_idx[KW-1:0]] : '0;
    wr_go = aw_hold && w_hold;
    rd_done = bus.rvalid && bus.rready;
  end
  // Write channel: address and data are latched independently; the register
  // update fires once both are held, and only then may the next pair be accepted.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      bus.awready <= 1'b0;
      bus.wready <= 1'b0;
      aw_hold <= 1'b0;
      w_hold <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
    end else begin
      bus.awready <= bus.awvalid && !bus.awready && !aw_hold;
      bus.wready <= bus.wvalid && !bus.wready && !w_hold;
      aw_hold <= wr_go ? 1'b0 : aw_hold || (bus.awvalid && bus.awready);
      w_hold <= wr_go ? 1'b0 : w_hold || (bus.wvalid && bus.wready);
      if (bus.awvalid && bus.awready) aw_addr <= bus.awaddr;
      if (bus.wvalid && bus.wready) w_data <= bus.wdata;
    end
  end
  // Read channel: one outstanding read; rd_ctrl remembers that the returned word was ap_ctrl.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      bus.arready <= 1'b0;
      bus.rvalid <= 1'b0;
      bus.rdata <= '0;
      rd_ctrl <= 1'b0;
    end else begin
      bus.arready <= bus.arvalid && !bus.arready && !bus.rvalid;
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1;
        bus.rdata <= rd_val;
        rd_ctrl <= bus.araddr == '0;
      end else if (rd_done) begin
        bus.rvalid <= 1'b0;
        bus.rdata <= '0;
        rd_ctrl <= 1'b0;
      end
    end
  end
  // Configuration registers are frozen while a frame is running.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      data_length <= '0;
      for (int i = 0; i < Tape_Num; i++) taps[i] <= '0;
    end else if (wr_go && ap_idle) begin
      if (aw_addr == A'('h10)) data_length <= w_data;
      if (wr_tap) taps[wr_idx[KW-1:0]] <= w_data;
    end
  end
  // Frame sequencer. Status-bit sets are placed after the read-clear so a
  // same-cycle event is never lost.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state <= S_IDLE;
      ap_start <= 1'b0;
      ap_done <= 1'b0;
      ap_idle <= 1'b1;
      tlast_err <= 1'b0;
      n <= '0;
      head <= '0;
      rp <= '0;
      k <= '0;
      acc <= '0;
      for (int i = 0; i < Tape_Num; i++) hist[i] <= '0;
      bus.ss_tready <= 1'b0;
      bus.sm_tvalid <= 1'b0;
      bus.sm_tdata <= '0;
      bus.sm_tlast <= 1'b0;
    end else begin
      if (rd_done && rd_ctrl) begin
        ap_done <= 1'b0;
        tlast_err <= 1'b0;
      end
      if (wr_go && ap_idle && aw_addr == '0 && w_data[0]) ap_start <= 1'b1;
      case (state)
        S_IDLE: if (ap_start) begin
          state <= S_CLR;
          ap_idle <= 1'b0;
          n <= '0;
        end
        S_CLR: begin
          for (int i = 0; i < Tape_Num; i++) hist[i] <= '0;
          head <= '0;
          state <= data_length == '0 ? S_DONE : S_WAIT_IN;
          bus.ss_tready <= data_length != '0;
        end
        S_WAIT_IN: if (bus.ss_tvalid && bus.ss_tready) begin
          hist[head] <= bus.ss_tdata;
          rp <= head;
          head <= head == K_LAST ? '0 : head + 1'b1;
          k <= '0;
          acc <= '0;
          ap_start <= 1'b0;
          bus.ss_tready <= 1'b0;
          if (bus.ss_tlast != last_n) tlast_err <= 1'b1;
          state <= S_MAC;
        end
        S_MAC: begin
          acc <= sum;
          k <= k + 1'b1;
          rp <= rp == '0 ? K_LAST : rp - 1'b1;
          if (k == K_LAST) begin
            state <= S_OUT;
            bus.sm_tvalid <= 1'b1;
            bus.sm_tdata <= result;
            bus.sm_tlast <= last_n;
          end
        end
        S_OUT: if (bus.sm_tready) begin
          bus.sm_tvalid <= 1'b0;
          bus.sm_tlast <= 1'b0;
          n <= n + W'(1);
          state <= n + W'(1) == data_length ? S_DONE : S_WAIT_IN;
          bus.ss_tready <= n + W'(1) != data_length;
        end
        S_DONE: begin
          ap_done <= 1'b1;
          ap_idle <= 1'b1;
          ap_start <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_param_core.sv
// tb_fir_param_core: directed self-checking bench for fir_param_core (11 taps, 32-bit)
`timescale 1ns/1ps
module tb_fir_param_core;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NT = 11;
`ifdef FIR_SAT_EN
  localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] OVF_NEG = 32'h8000_0000;
`else
  localparam logic [31:0] OVF_POS = 32'hFFFF_FFFE;
  localparam logic [31:0] OVF_NEG = 32'h0000_0002;
`endif
  logic axis_clk = 1'b0;
  logic axis_rst_n = 1'b0;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  logic signed [31:0] gold [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  logic signed [31:0] step [12] = '{0, -10, -19, 4, 60, 123, 179, 202, 193, 183, 183, 183};
  logic [31:0] r, y;
  logic yl;
  int lat, hs_edge, prev_hs;
  fir_param_core_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();
  fir_param_core #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
    .axis_clk(axis_clk),
    .axis_rst_n(axis_rst_n),
    .bus(bus)
  );
  always #5 axis_clk = ~axis_clk;
  always @(posedge axis_clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    int t = 0;
    bit ag = 0, wg = 0;
    bus.awvalid = 1; bus.awaddr = a; bus.wvalid = 1; bus.wdata = d;
    while ((bus.awvalid || bus.wvalid) && t < 50) begin
      @(negedge axis_clk); t++;
      if (ag) bus.awvalid = 0;
      if (wg) bus.wvalid = 0;
      if (bus.awvalid && bus.awready) ag = 1;
      if (bus.wvalid && bus.wready) wg = 1;
    end
    check("wr_wait", t < 50, 1);
    bus.awvalid = 0; bus.wvalid = 0;
    repeat (2) @(negedge axis_clk);
  endtask
  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    int t = 0;
    bit ag = 0, got = 0;
    bus.arvalid = 1; bus.araddr = a; bus.rready = 1; d = '0;
    while (!got && t < 50) begin
      @(negedge axis_clk); t++;
      if (ag) bus.arvalid = 0;
      if (bus.arvalid && bus.arready) ag = 1;
      if (bus.rvalid) begin d = bus.rdata; got = 1; end
    end
    check("rd_wait", got, 1);
    @(negedge axis_clk);
    bus.rready = 0; bus.arvalid = 0;
  endtask
  // One sample in, one result out; optionally hold sm_tready low for `stall` cycles.
  task automatic xfer(input logic [31:0] x, input logic l, input int stall);
    int t = 0;
    logic [31:0] y0;
    bit held = 1;
    bus.ss_tvalid = 1; bus.ss_tdata = x; bus.ss_tlast = l;
    while (!bus.ss_tready && t < 100) begin @(negedge axis_clk); t++; end
    check("ss_wait", t < 100, 1);
    prev_hs = hs_edge;
    hs_edge = cyc + 1;
    @(negedge axis_clk);
    bus.ss_tvalid = 0; bus.ss_tlast = 0;
    t = 0;
    while (!bus.sm_tvalid && t < 100) begin @(negedge axis_clk); t++; end
    check("sm_wait", t < 100, 1);
    lat = cyc + 1 - hs_edge;
    if (stall > 0) begin
      bus.sm_tready = 0;
      y0 = bus.sm_tdata;
      repeat (stall) begin
        @(negedge axis_clk);
        held &= bus.sm_tvalid && bus.sm_tdata == y0 && !bus.ss_tready;
      end
      check("stall_hold", held, 1);
      bus.sm_tready = 1;
    end
    y = bus.sm_tdata; yl = bus.sm_tlast;
    @(negedge axis_clk);
  endtask
  task automatic load_taps();
    for (int k = 0; k < NT; k++) axi_write(12'h40 + 12'(4 * k), gold[k]);
  endtask
  task automatic start_frame(input int len);
    axi_write(12'h10, len);
    axi_write(12'h00, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0;
    bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
    bus.ss_tvalid = 0; bus.ss_tdata = '0; bus.ss_tlast = 0; bus.sm_tready = 1;
    hs_edge = 0; prev_hs = 0;
    repeat (3) @(negedge axis_clk);
    check("rst_awready", bus.awready, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_ss_tready", bus.ss_tready, 0);
    check("rst_sm_tvalid", bus.sm_tvalid, 0);
    check("rst_sm_tdata", bus.sm_tdata, 0);
    axis_rst_n = 1;
    @(negedge axis_clk);
    // 1: register access
    axi_read(12'h00, r); check("ctrl_reset", r, 32'h4);
    axi_write(12'h10, 600);
    axi_read(12'h10, r); check("dlen_600", r, 600);
    fork
      axi_write(12'h48, 77);
      begin axi_read(12'h10, r); check("par_rd", r, 600); end
    join
    axi_read(12'h48, r); check("par_wr", r, 77);
    load_taps();
    for (int k = 0; k < NT; k++) begin
      axi_read(12'h40 + 12'(4 * k), r);
      check($sformatf("tap_rb%0d", k), r, gold[k]);
    end
    axi_write(12'h6C, 5);
    axi_read(12'h6C, r); check("unmapped", r, 0);
    axi_read(12'h68, r); check("tap10_intact", r, 0);
    // 2: impulse response
    start_frame(11);
    for (int i = 0; i < NT; i++) begin
      xfer(i == 0, i == NT - 1, 0);
      check($sformatf("imp_y%0d", i), y, gold[i]);
      check($sformatf("imp_last%0d", i), yl, i == NT - 1);
      if (i == 0) check("latency", lat, NT + 1);
      if (i == 1) check("interval", hs_edge - prev_hs, NT + 2);
    end
    axi_read(12'h00, r); check("ctrl_done", r, 32'h6);
    axi_read(12'h00, r); check("ctrl_clr", r, 32'h4);
    // 3: step input with backpressure on output 3
    start_frame(12);
    for (int i = 0; i < 12; i++) begin
      xfer(1, i == 11, i == 3 ? 20 : 0);
      check($sformatf("step_y%0d", i), y, step[i]);
      if (i == 0) check("step_latency", lat, NT + 1);
    end
    check("step_last", yl, 1);
    axi_read(12'h00, r); check("step_done", r, 32'h6);
    // 4: write protection mid-frame
    start_frame(4);
    xfer(1, 0, 0); check("wp_y0", y, 0);
    xfer(0, 0, 0); check("wp_y1", y, 32'hFFFF_FFF6);
    axi_write(12'h40, 99);
    axi_write(12'h10, 7);
    axi_read(12'h40, r); check("wp_tap0", r, 0);
    axi_read(12'h10, r); check("wp_dlen", r, 4);
    axi_read(12'h00, r); check("ctrl_busy", r, 0);
    xfer(0, 0, 0); check("wp_y2", y, 32'hFFFF_FFF7);
    xfer(0, 1, 0); check("wp_y3", y, 23); check("wp_last", yl, 1);
    axi_read(12'h00, r); check("wp_done", r, 32'h6);
    axi_read(12'h00, r); check("wp_done_clr", r, 32'h4);
    // 5: overflow, then an empty frame
    for (int k = 1; k < NT; k++) axi_write(12'h40 + 12'(4 * k), 0);
    axi_write(12'h40, 32'h7FFF_FFFF);
    start_frame(1);
    xfer(2, 1, 0); check("ovf_pos", y, OVF_POS);
    start_frame(1);
    xfer(32'hFFFF_FFFE, 1, 0); check("ovf_neg", y, OVF_NEG);
    axi_read(12'h00, r); check("ovf_done", r, 32'h6);
    start_frame(0);
    repeat (4) @(negedge axis_clk);
    axi_read(12'h00, r); check("zero_len_done", r, 32'h6);
    // 6: mid-frame reset, rerun, tlast error
    load_taps();
    start_frame(11);
    for (int i = 0; i < 5; i++) begin
      xfer(i == 0, 0, 0);
      check($sformatf("pre_rst_y%0d", i), y, gold[i]);
    end
    #2 axis_rst_n = 0;
    #1;
    check("arst_ss_tready", bus.ss_tready, 0);
    check("arst_sm_tvalid", bus.sm_tvalid, 0);
    check("arst_sm_tdata", bus.sm_tdata, 0);
    @(negedge axis_clk);
    axis_rst_n = 1;
    @(negedge axis_clk);
    axi_read(12'h00, r); check("arst_ctrl", r, 32'h4);
    axi_read(12'h50, r); check("arst_tap4", r, 0);
    axi_read(12'h10, r); check("arst_dlen", r, 0);
    load_taps();
    start_frame(11);
    for (int i = 0; i < NT; i++) begin
      xfer(i == 0, i == NT - 1, 0);
      check($sformatf("rerun_y%0d", i), y, gold[i]);
    end
    axi_read(12'h00, r); check("rerun_done", r, 32'h6);
    start_frame(5);
    for (int i = 0; i < 5; i++) begin
      xfer(i == 0, i == 2, 0);
      check($sformatf("tl_y%0d", i), y, gold[i]);
      check($sformatf("tl_last%0d", i), yl, i == 4);
    end
    axi_read(12'h00, r); check("tlast_err", r, 32'hE);
    axi_read(12'h00, r); check("tlast_err_clr", r, 32'h4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
